stack_ctrl: RTL
===============

Name: stack_ctrl

Overview:
- Sequencer for the hardware return-address stack.
- Decodes DA/AA register-select fields against the SP code and classifies each request as push, pop, push+pop or none.
- Tracks depth and flags overflow/underflow; a FAULT state blocks traffic until software clears it.
- Sits between instruction decode and stack storage; owns all storage enables.

Parameters:
DEPTH, 4, number of stack entries (power of 2, >=2)
WIDTH, 32, data width
SP_CODE, 5'b11110, register code that selects the stack in DA/AA
RET_OFFSET, 4, constant added to DataIn on push (return address = PC+4)

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  reset, asynchronous, active-low
req_valid  input  1  decode presents DA/AA/DataIn this cycle
req_ready  output  1  controller accepts the request this cycle
DA  input  5  destination field; DA==SP_CODE means push
AA  input  5  source-A field; AA==SP_CODE means pop
DataIn  input  WIDTH  push data (PC)
DataO  output  WIDTH  popped value, registered
DataO_valid  output  1  one-cycle pulse, DataO holds a popped value
depth  output  $clog2(DEPTH)+1  current entry count
full  output  1  depth==DEPTH
empty  output  1  depth==0
overflow_err  output  1  sticky, push refused at full
underflow_err  output  1  sticky, pop refused at empty
err_clr  input  1  clears sticky errors, FAULT -> RUN

Behaviour:
- Reset (RST low, async):
  - FSM=RUN; depth=0; DataO=0; DataO_valid=0; overflow_err=0; underflow_err=0.
  - Storage pointer=0; storage contents need not be cleared.
- FSM states:
  - RUN: req_ready=1.
  - FAULT: req_ready=0; requests ignored; DataO_valid=0.
  - FAULT -> RUN on err_clr=1 (errors clear the same edge).
  - err_clr in RUN clears nothing and is harmless.
- Accept condition: req_valid & req_ready. Non-accepted cycles change nothing; DataO_valid=0.
- Push only (DA==SP_CODE, AA!=SP_CODE):
  - Not full: top <= DataIn+RET_OFFSET (mod 2^WIDTH); depth+1.
  - Full: no write; overflow_err=1; FSM->FAULT.
- Pop only (AA==SP_CODE, DA!=SP_CODE):
  - Not empty: DataO <= top; DataO_valid=1 next cycle (latency 1); depth-1.
  - Empty: DataO unchanged; DataO_valid=0; underflow_err=1; FSM->FAULT.
- Push+pop same cycle:
  - Not empty: DataO <= old top; DataO_valid=1; top replaced by DataIn+RET_OFFSET; depth unchanged; never overflows.
  - Empty: bypass, DataO <= DataIn+RET_OFFSET; DataO_valid=1; depth stays 0; no error.
- Neither field matches: no-op, req_ready still 1.
- full/empty/depth are registered, reflect state after the last edge.
- Back-to-back requests accepted every cycle in RUN.
- Reset mid-operation: pending DataO_valid pulse dropped; all state returns to reset values immediately.

Optional Feature:
STACK_CTRL_WRAP_EN
- Defined: push at full overwrites the oldest entry (circular). Depth stays DEPTH, no overflow_err, no FAULT. Underflow behaviour unchanged.
- Undefined: push at full faults as above.

Decomposition:
- Package stack_pkg: SP_CODE, RET_OFFSET, FSM state enum {RUN, FAULT}, op enum {OP_NONE, OP_PUSH, OP_POP, OP_SWAP}.
- Sub-module stack_mem: DEPTH x WIDTH circular array with top pointer.
  - Inputs: wr_en, rd_en, replace_en; outputs: top.
  - stack_ctrl keeps the FSM, depth counter, decode, error logic and DataO register.

Test Plan:
- Reset, then push DataIn=0x100, 0x200 -> depth=2; pop -> DataO=0x204, DataO_valid one cycle later, depth=1.
- Push 4 values (0x10,0x20,0x30,0x40), 5th push 0x50 -> overflow_err=1, req_ready=0, depth=4; err_clr -> req_ready=1; pops return 0x44,0x34,0x24,0x14.
- Pop on empty -> underflow_err=1, DataO_valid=0, FAULT; request during FAULT is ignored (depth unchanged).
- Depth 1 (top 0x84), push+pop with DataIn=0x300 -> DataO=0x84, depth=1; next pop -> DataO=0x304.
- Empty, push+pop with DataIn=0xFFFFFFFE -> DataO=0x00000002 (wrap), depth=0, no error.
- With STACK_CTRL_WRAP_EN: 5 pushes of 0x0..0x4 -> no error, depth=4; 4 pops return 0x8,0x7,0x6,0x5.

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg: shared constants and types for the return-address stack controller.
//   SP_CODE     register code that selects the stack in the DA/AA fields
//   RET_OFFSET  constant added to the pushed PC (return address = PC + 4)
//   state_e     controller FSM states
//   op_e        decoded request class
package stack_pkg;

   localparam logic [4:0]  SP_CODE    = 5'b11110;
   localparam int unsigned RET_OFFSET = 4;

   typedef enum logic {
      RUN,
      FAULT
   } state_e;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_SWAP
   } op_e;

   // Classify a request from the two field-match bits.
   function automatic op_e decode_op(input logic push_hit, input logic pop_hit);
      op_e op;
      unique case ({push_hit, pop_hit})
         2'b10:   op = OP_PUSH;
         2'b01:   op = OP_POP;
         2'b11:   op = OP_SWAP;
         default: op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/stack_mem.sv
// stack_mem: DEPTH x WIDTH circular storage with a top-of-stack pointer.
//   clk_i         clock
//   rst_ni        asynchronous active-low reset (pointer only; contents are not cleared)
//   wr_en_i       push: advance pointer and write wr_data_i at the new top
//   rd_en_i       pop: retreat pointer
//   replace_en_i  overwrite the current top with wr_data_i, pointer unchanged
//   wr_data_i     write data
//   top_o         current top-of-stack entry
// The pointer wraps modulo DEPTH, so a push at full lands on the oldest entry.
module stack_mem #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic             rd_en_i,
   input  logic             replace_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic [WIDTH-1:0] top_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    wr_idx;

   always_comb begin
      ptr_d  = ptr_q;
      wr_idx = ptr_q;
      if (wr_en_i) begin
         ptr_d  = ptr_q + PW'(1);
         wr_idx = ptr_d;
      end else if (rd_en_i) begin
         ptr_d  = ptr_q - PW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i || replace_en_i) begin
         mem_q[wr_idx] <= wr_data_i;
      end
   end

   assign top_o = mem_q[ptr_q];

endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequencer for the hardware return-address stack.
// Decodes DA/AA against SP_CODE into push / pop / push+pop / none, tracks depth,
// flags overflow/underflow and parks in FAULT until software pulses err_clr.
//   CLK, RST        clock, asynchronous active-low reset
//   req_valid/ready request handshake (ready is low only in FAULT)
//   DA, AA          destination / source-A register fields
//   DataIn          PC to push (stored as DataIn + RET_OFFSET)
//   DataO, _valid   registered popped value and its one-cycle strobe
//   depth/full/empty registered occupancy
//   overflow_err, underflow_err  sticky errors, cleared by err_clr
// Build option: define STACK_CTRL_WRAP_EN to make a push at full overwrite the
// oldest entry instead of faulting.
module stack_ctrl #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned WIDTH      = 32,
   parameter logic [4:0]  SP_CODE    = stack_pkg::SP_CODE,
   parameter int unsigned RET_OFFSET = stack_pkg::RET_OFFSET
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [4:0]               DA,
   input  logic [4:0]               AA,
   input  logic [WIDTH-1:0]         DataIn,
   output logic [WIDTH-1:0]         DataO,
   output logic                     DataO_valid,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow_err,
   output logic                     underflow_err,
   input  logic                     err_clr
);

   import stack_pkg::*;

   localparam int unsigned DW = $clog2(DEPTH) + 1;

   state_e           state_q, state_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic             full_q, empty_q;
   logic [WIDTH-1:0] data_o_q, data_o_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             accept;
   op_e              op;
   logic [WIDTH-1:0] push_data;
   logic [WIDTH-1:0] mem_top;
   logic             wr_en, rd_en, replace_en;

   assign req_ready = (state_q == RUN);
   assign accept    = req_valid && req_ready;
   assign op        = decode_op(DA == SP_CODE, AA == SP_CODE);
   assign push_data = DataIn + WIDTH'(RET_OFFSET);

   always_comb begin
      state_d    = state_q;
      depth_d    = depth_q;
      data_o_d   = data_o_q;
      valid_d    = 1'b0;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      replace_en = 1'b0;

      unique case (state_q)
         RUN: begin
            if (accept) begin
               unique case (op)
                  OP_PUSH: begin
                     if (!full_q) begin
                        wr_en   = 1'b1;
                        depth_d = depth_q + DW'(1);
                     end else begin
`ifdef STACK_CTRL_WRAP_EN
                        // Circular overwrite of the oldest entry; depth stays at DEPTH.
                        wr_en   = 1'b1;
`else
                        ovf_d   = 1'b1;
                        state_d = FAULT;
`endif
                     end
                  end
                  OP_POP: begin
                     if (!empty_q) begin
                        rd_en    = 1'b1;
                        data_o_d = mem_top;
                        valid_d  = 1'b1;
                        depth_d  = depth_q - DW'(1);
                     end else begin
                        unf_d   = 1'b1;
                        state_d = FAULT;
                     end
                  end
                  OP_SWAP: begin
                     valid_d = 1'b1;
                     if (!empty_q) begin
                        data_o_d   = mem_top;
                        replace_en = 1'b1;
                     end else begin
                        // Nothing stored: the pushed value passes straight through.
                        data_o_d = push_data;
                     end
                  end
                  default: ;
               endcase
            end
         end
         FAULT: begin
            if (err_clr) begin
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= RUN;
         depth_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         data_o_q <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         depth_q  <= depth_d;
         full_q   <= (depth_d == DW'(DEPTH));
         empty_q  <= (depth_d == '0);
         data_o_q <= data_o_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   stack_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk_i        (CLK),
      .rst_ni       (RST),
      .wr_en_i      (wr_en),
      .rd_en_i      (rd_en),
      .replace_en_i (replace_en),
      .wr_data_i    (push_data),
      .top_o        (mem_top)
   );

   assign DataO         = data_o_q;
   assign DataO_valid   = valid_q;
   assign depth         = depth_q;
   assign full          = full_q;
   assign empty         = empty_q;
   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;

endmodule
